// File: rtl/uart_pkt_tx.sv
// Packet-aware UART transmitter: a byte FIFO of {eop, data} entries feeds a
// start/8-data/stop serialiser that inserts an idle gap after each packet.
module uart_pkt_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 2,
  parameter int GAP_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_eop,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          txd
);

  localparam int CPB     = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int PtrW    = $clog2(FIFO_DEPTH);
  localparam int TimerW  = $clog2(CPB);
  localparam int MaxBits = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int CntW    = $clog2(MaxBits);

  if (CPB < 4) begin : genCpbCheck
    $error("uart_pkt_tx: CLK_FREQ/BAUD gives fewer than 4 clocks per bit");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : genDepthCheck
    $error("uart_pkt_tx: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : genStopCheck
    $error("uart_pkt_tx: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS < 1) begin : genGapCheck
    $error("uart_pkt_tx: GAP_BITS must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} stateT;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wrPtr, rdPtr;
  logic [PtrW:0]     count;
  logic              doWrite, doPop, fifoEmpty;
  logic [8:0]        headEntry;

  stateT             state, stateNext;
  logic [TimerW-1:0] bitTimer, bitTimerNext;
  logic [CntW-1:0]   bitCnt, bitCntNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              eopLatch, eopNext, txdNext, pktDoneNext;
  logic              bitEnd, startFrame;

  assign fifoEmpty = (count == '0);
  assign full      = (count == (PtrW + 1)'(FIFO_DEPTH));
  assign level     = count;
  assign doWrite   = wr_en && !full;
  assign headEntry = mem[rdPtr];
  assign bitEnd    = (bitTimer == '0);
  assign busy      = (state != IDLE) || !fifoEmpty;

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= {wr_eop, wr_data};
  end

  // The full flag is taken from the registered count, so a pop in the same
  // cycle never rescues a write that arrived while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      unique case ({doWrite, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitTimer <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      eopLatch <= 1'b0;
      txd      <= 1'b1;
      pkt_done <= 1'b0;
    end else begin
      state    <= stateNext;
      bitTimer <= bitTimerNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      eopLatch <= eopNext;
      txd      <= txdNext;
      pkt_done <= pktDoneNext;
    end
  end

  // The bit timer reloads on every boundary so each bit is exactly CPB clocks;
  // startFrame collects both ways of popping a new byte into the START bit.
  always_comb begin
    stateNext    = state;
    bitTimerNext = bitTimer;
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    eopNext      = eopLatch;
    txdNext      = txd;
    pktDoneNext  = 1'b0;
    doPop        = 1'b0;
    startFrame   = 1'b0;

    if (state != IDLE) begin
      bitTimerNext = bitEnd ? TimerW'(CPB - 1) : bitTimer - 1'b1;
    end

    case (state)
      IDLE: begin
        txdNext = 1'b1;
        if (!fifoEmpty) startFrame = 1'b1;
      end
      START: begin
        if (bitEnd) begin
          txdNext    = shiftReg[0];
          shiftNext  = {1'b0, shiftReg[7:1]};
          bitCntNext = '0;
          stateNext  = DATA;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitCnt == CntW'(7)) begin
            txdNext    = 1'b1;
            bitCntNext = '0;
            stateNext  = STOP;
          end else begin
            txdNext    = shiftReg[0];
            shiftNext  = {1'b0, shiftReg[7:1]};
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (bitCnt == CntW'(STOP_BITS - 1)) begin
            bitCntNext = '0;
            if (eopLatch) begin
              txdNext   = 1'b1;
              stateNext = GAP;
            end else if (!fifoEmpty) begin
              startFrame = 1'b1;
            end else begin
              txdNext   = 1'b1;
              stateNext = IDLE;
            end
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (bitEnd) begin
          if (bitCnt == CntW'(GAP_BITS - 1)) begin
            bitCntNext  = '0;
            pktDoneNext = 1'b1;
            stateNext   = IDLE;
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (startFrame) begin
      doPop        = 1'b1;
      shiftNext    = headEntry[7:0];
      eopNext      = headEntry[8];
      txdNext      = 1'b0;
      bitTimerNext = TimerW'(CPB - 1);
      stateNext    = START;
    end
  end

endmodule
